// File: rtl/green_prmgmt_pkg.sv
// Shared command codes, register map and STATUS layout for the green-region management slave.
package green_prmgmt_pkg;

  typedef enum logic [15:0] {
    CMD_IDLE    = 16'd0,
    CMD_WRITE   = 16'd1,
    CMD_READ    = 16'd2,
    CMD_CLR_ERR = 16'd3
  } t_prmgmt_cmd;

  localparam logic [15:0] ADDR_SCRATCH = 16'h0000;
  localparam logic [15:0] ADDR_CTRL    = 16'h0001;
  localparam logic [15:0] ADDR_STATUS  = 16'h0002;
  localparam logic [15:0] ADDR_ERRCNT  = 16'h0003;
  localparam logic [15:0] ADDR_ID      = 16'h0004;
  localparam logic [15:0] RAM_BASE     = 16'h0100;

  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned RAM_AW    = 8;

  localparam int unsigned ST_INIT_BUSY    = 0;
  localparam int unsigned ST_INIT_DONE    = 1;
  localparam int unsigned ST_TIMEOUT      = 2;
  localparam int unsigned ST_BLK_LOCK_LSB = 8;

  function automatic logic is_ram_addr(input logic [15:0] addr);
    return (addr >= RAM_BASE) && (addr < (RAM_BASE + 16'(RAM_DEPTH)));
  endfunction

endpackage

// File: rtl/green_prmgmt_init_seq.sv
// HSSI init handshake: raises init_start until synchronised init_done rises, faults after INIT_TIMEOUT cycles.
module green_prmgmt_init_seq #(
  parameter int unsigned INIT_TIMEOUT = 1000000
) (
  input  logic prmgmt_ctrl_clk,
  input  logic prmgmt_arst,
  input  logic freeze,
  input  logic start_req,
  input  logic clr_err,
  input  logic init_done,
  output logic init_start,
  output logic timeout,
  output logic done_sync
);

  localparam int unsigned CNT_W = $clog2(INIT_TIMEOUT + 1);

  typedef enum logic [1:0] {I_IDLE, I_BUSY, I_FAULT} t_init_state;

  t_init_state      state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             timeout_nxt;
  logic             done_meta, done_prev, done_rise;

  assign done_rise = done_sync && !done_prev;

  always_ff @(posedge prmgmt_ctrl_clk or posedge prmgmt_arst) begin
    if (prmgmt_arst) begin
      state <= I_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Freeze holds everything; a timeout in the same cycle as CLR_ERR keeps the fault.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_q;
    timeout_nxt = timeout;
    if (!freeze) begin
      if (clr_err) timeout_nxt = 1'b0;
      case (state)
        I_IDLE: begin
          if (start_req) begin
            state_nxt = I_BUSY;
            cnt_nxt   = '0;
          end
        end
        I_BUSY: begin
          if (done_rise) begin
            state_nxt = I_IDLE;
          end else if (cnt_q == CNT_W'(INIT_TIMEOUT - 1)) begin
            state_nxt   = I_FAULT;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        I_FAULT: begin
          if (clr_err) state_nxt = I_IDLE;
        end
        default: state_nxt = I_IDLE;
      endcase
    end
  end

  always_ff @(posedge prmgmt_ctrl_clk or posedge prmgmt_arst) begin
    if (prmgmt_arst) begin
      cnt_q      <= '0;
      timeout    <= 1'b0;
      init_start <= 1'b0;
      done_meta  <= 1'b0;
      done_sync  <= 1'b0;
      done_prev  <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      timeout    <= timeout_nxt;
      init_start <= (state_nxt == I_BUSY);
      done_meta  <= init_done;
      done_sync  <= done_meta;
      if (!freeze) done_prev <= done_sync;
    end
  end

endmodule

// File: rtl/green_prmgmt_ctrl.sv
// Management-port slave in the green region: command decode, CSR file, scratch RAM and init sequencing.
module green_prmgmt_ctrl
  import green_prmgmt_pkg::*;
#(
  parameter int unsigned NUM_LN       = 4,
  parameter int unsigned INIT_TIMEOUT = 1000000,
  parameter logic [31:0] BLOCK_ID     = 32'hC0DE_0001
) (
  input  logic              prmgmt_ctrl_clk,
  input  logic              prmgmt_arst,
  input  logic [15:0]       prmgmt_cmd,
  input  logic [15:0]       prmgmt_addr,
  input  logic [31:0]       prmgmt_din,
  output logic [31:0]       prmgmt_dout,
  input  logic              prmgmt_freeze,
  input  logic              prmgmt_ram_ena,
  output logic              prmgmt_fatal_err,
  output logic              init_start,
  input  logic              init_done,
  input  logic [NUM_LN-1:0] rx_enh_blk_lock
);

  typedef enum logic [1:0] {C_IDLE, C_EXEC, C_RESP, C_WAIT} t_cmd_state;

  t_cmd_state        state, state_nxt;
  logic [15:0]       cmd_q;
  logic [31:0]       scratch_q;
  logic [15:0]       errcnt_q;
  logic [NUM_LN-1:0] lock_meta, lock_sync;
  logic [31:0]       rd_reg_q, ram_rdata, rd_reg, status;
  logic              rd_ram_q, rd_err_q;
  logic              exec, is_wr, is_rd, in_ram, in_reg, ro_reg, ctrl_set;
  logic              acc_err, cmd_err, wr_ok, start_req, scratch_we, ram_we, clr_err;
  logic              timeout, done_sync;
  logic [31:0]       ram [RAM_DEPTH];

  // The sequencer's timeout flag doubles as the fatal error and as the I_FAULT indication.
  assign prmgmt_fatal_err = timeout;

  always_ff @(posedge prmgmt_ctrl_clk or posedge prmgmt_arst) begin
    if (prmgmt_arst) begin
      state <= C_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:  if (prmgmt_cmd != 16'd0) state_nxt = C_EXEC;
      C_EXEC:  state_nxt = C_RESP;
      C_RESP:  state_nxt = C_WAIT;
      C_WAIT:  if (prmgmt_cmd == 16'd0) state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
    if (prmgmt_freeze) state_nxt = state;
  end

  // Decode of the command being executed against the live address/data.
  always_comb begin
    exec       = (state == C_EXEC) && !prmgmt_freeze;
    is_wr      = (cmd_q == CMD_WRITE);
    is_rd      = (cmd_q == CMD_READ);
    in_ram     = is_ram_addr(prmgmt_addr);
    in_reg     = (prmgmt_addr <= ADDR_ID);
    ro_reg     = (prmgmt_addr == ADDR_STATUS) || (prmgmt_addr == ADDR_ERRCNT) ||
                 (prmgmt_addr == ADDR_ID);
    ctrl_set   = (prmgmt_addr == ADDR_CTRL) && prmgmt_din[0];
    acc_err    = (is_wr || is_rd) &&
                 (!(in_reg || in_ram) || (in_ram && !prmgmt_ram_ena) ||
                  (is_wr && ro_reg) || (is_wr && ctrl_set && timeout));
    cmd_err    = exec && ((cmd_q > CMD_CLR_ERR) || acc_err);
    wr_ok      = exec && is_wr && !acc_err;
    start_req  = wr_ok && ctrl_set;
    scratch_we = wr_ok && (prmgmt_addr == ADDR_SCRATCH);
    ram_we     = wr_ok && in_ram;
    clr_err    = exec && (cmd_q == CMD_CLR_ERR);
  end

  always_comb begin
    status                                 = '0;
    status[ST_INIT_BUSY]                   = init_start;
    status[ST_INIT_DONE]                   = done_sync;
    status[ST_TIMEOUT]                     = timeout;
    status[ST_BLK_LOCK_LSB +: NUM_LN]      = lock_sync;
  end

  always_comb begin
    rd_reg = '0;
    case (prmgmt_addr)
      ADDR_SCRATCH: rd_reg = scratch_q;
      ADDR_CTRL:    rd_reg = 32'(init_start);
      ADDR_STATUS:  rd_reg = status;
      ADDR_ERRCNT:  rd_reg = 32'(errcnt_q);
      ADDR_ID:      rd_reg = BLOCK_ID;
      default:      rd_reg = '0;
    endcase
  end

  always_ff @(posedge prmgmt_ctrl_clk or posedge prmgmt_arst) begin
    if (prmgmt_arst) begin
      cmd_q       <= '0;
      scratch_q   <= '0;
      errcnt_q    <= '0;
      rd_reg_q    <= '0;
      rd_ram_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      prmgmt_dout <= '0;
      lock_meta   <= '0;
      lock_sync   <= '0;
    end else begin
      lock_meta <= rx_enh_blk_lock;
      lock_sync <= lock_meta;
      if ((state == C_IDLE) && (state_nxt == C_EXEC)) cmd_q <= prmgmt_cmd;
      if (exec) begin
        rd_reg_q <= rd_reg;
        rd_ram_q <= in_ram;
        rd_err_q <= acc_err;
      end
      if (scratch_we) scratch_q <= prmgmt_din;
      if (clr_err) begin
        errcnt_q <= '0;
      end else if (cmd_err && (errcnt_q != 16'hFFFF)) begin
        errcnt_q <= errcnt_q + 16'd1;
      end
      if ((state == C_RESP) && !prmgmt_freeze && is_rd) begin
        prmgmt_dout <= rd_err_q ? 32'd0 : (rd_ram_q ? ram_rdata : rd_reg_q);
      end
    end
  end

  // Scratch RAM: no reset, contents undefined after reset.
  always_ff @(posedge prmgmt_ctrl_clk) begin
    if (ram_we) ram[prmgmt_addr[RAM_AW-1:0]] <= prmgmt_din;
    if (exec) ram_rdata <= ram[prmgmt_addr[RAM_AW-1:0]];
  end

  green_prmgmt_init_seq #(
    .INIT_TIMEOUT (INIT_TIMEOUT)
  ) u_init_seq (
    .prmgmt_ctrl_clk (prmgmt_ctrl_clk),
    .prmgmt_arst     (prmgmt_arst),
    .freeze          (prmgmt_freeze),
    .start_req       (start_req),
    .clr_err         (clr_err),
    .init_done       (init_done),
    .init_start      (init_start),
    .timeout         (timeout),
    .done_sync       (done_sync)
  );

endmodule

// File: tb/tb_green_prmgmt_ctrl.sv
// Self-checking bench: directed scenarios plus random register/RAM traffic against a transaction-level model.
module tb_green_prmgmt_ctrl;

  localparam int unsigned NUM_LN = 4;
  localparam int unsigned TMO    = 100;

  logic              clk = 1'b0;
  logic              arst;
  logic [15:0]       cmd, addr;
  logic [31:0]       din, dout;
  logic              freeze, ram_ena, fatal_err, init_start, init_done;
  logic [NUM_LN-1:0] lock;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model of the visible state
  logic [31:0] m_scratch;
  int          m_errcnt;
  logic [31:0] m_ram [256];
  bit          m_ram_v [256];
  bit          m_busy, m_timeout, m_done;

  always #5 clk = ~clk;

  green_prmgmt_ctrl #(
    .NUM_LN       (NUM_LN),
    .INIT_TIMEOUT (TMO),
    .BLOCK_ID     (32'hC0DE_0001)
  ) dut (
    .prmgmt_ctrl_clk  (clk),
    .prmgmt_arst      (arst),
    .prmgmt_cmd       (cmd),
    .prmgmt_addr      (addr),
    .prmgmt_din       (din),
    .prmgmt_dout      (dout),
    .prmgmt_freeze    (freeze),
    .prmgmt_ram_ena   (ram_ena),
    .prmgmt_fatal_err (fatal_err),
    .init_start       (init_start),
    .init_done        (init_done),
    .rx_enh_blk_lock  (lock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_scratch = '0;
    m_errcnt  = 0;
    m_busy    = 1'b0;
    m_timeout = 1'b0;
    for (int i = 0; i < 256; i++) m_ram_v[i] = 1'b0;
  endtask

  function automatic bit m_is_err(input logic [15:0] c, input logic [15:0] a, input logic [31:0] d);
    if (c > 16'd3) return 1'b1;
    if (c != 16'd1 && c != 16'd2) return 1'b0;
    if (a >= 16'h0100 && a < 16'h0200) return !ram_ena;
    if (a > 16'h0004) return 1'b1;
    if (c == 16'd1 && a >= 16'h0002) return 1'b1;
    if (c == 16'd1 && a == 16'h0001 && d[0] && m_timeout) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_reg(input logic [15:0] a);
    if (a == 16'h0000) return m_scratch;
    if (a == 16'h0001) return 32'(m_busy);
    if (a == 16'h0002) return (32'(lock) << 8) | 32'({m_timeout, m_done, m_busy});
    if (a == 16'h0003) return 32'(m_errcnt);
    return 32'hC0DE_0001;
  endfunction

  // One host handshake: present command, pick up dout two cycles after sampling, return to IDLE.
  task automatic do_cmd(input logic [15:0] c, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    @(negedge clk);
    cmd = c; addr = a; din = d;
    repeat (3) @(negedge clk);
    rd  = dout;
    cmd = 16'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic txn(input logic [15:0] c, input logic [15:0] a, input logic [31:0] d,
                     input string tag);
    logic [31:0] rd, exp;
    bit err, do_chk;
    err    = m_is_err(c, a, d);
    do_chk = (c == 16'd2);
    exp    = '0;
    if (c == 16'd2 && !err) begin
      if (a >= 16'h0100 && a < 16'h0200) begin
        exp    = m_ram[a[7:0]];
        do_chk = m_ram_v[a[7:0]];
      end else begin
        exp = m_reg(a);
      end
    end
    do_cmd(c, a, d, rd);
    if (do_chk) check(tag, rd, exp);
    if (err) begin
      if (m_errcnt < 65535) m_errcnt++;
    end else if (c == 16'd3) begin
      m_errcnt  = 0;
      m_timeout = 1'b0;
    end else if (c == 16'd1) begin
      if (a == 16'h0000) m_scratch = d;
      else if (a == 16'h0001 && d[0]) m_busy = 1'b1;
      else if (a >= 16'h0100 && a < 16'h0200) begin
        m_ram[a[7:0]]   = d;
        m_ram_v[a[7:0]] = 1'b1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] c, a;
    logic [31:0] d;
    arst = 1'b1; cmd = '0; addr = '0; din = '0; freeze = 1'b0; ram_ena = 1'b1;
    init_done = 1'b0; lock = 4'b1010; m_done = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'd0);
    check("rst_fatal", 32'(fatal_err), 32'd0);
    check("rst_init_start", 32'(init_start), 32'd0);
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic ID / scratch access
    txn(16'd2, 16'h0004, 32'd0, "rd_id");
    txn(16'd1, 16'h0000, 32'hA5A5_5A5A, "wr_scratch");
    txn(16'd2, 16'h0000, 32'd0, "rd_scratch");
    txn(16'd2, 16'h0002, 32'd0, "rd_status_lock");

    // RAM window top word, then blocked window
    txn(16'd1, 16'h01FF, 32'h0000_1234, "wr_ram_top");
    txn(16'd2, 16'h01FF, 32'd0, "rd_ram_top");
    ram_ena = 1'b0;
    txn(16'd2, 16'h01FF, 32'd0, "rd_ram_disabled");
    txn(16'd2, 16'h0003, 32'd0, "errcnt_ram_dis");
    ram_ena = 1'b1;

    // A held command executes once
    @(negedge clk);
    cmd = 16'd2; addr = 16'h0200;
    repeat (10) @(negedge clk);
    cmd = 16'd0;
    repeat (2) @(negedge clk);
    m_errcnt++;
    txn(16'd2, 16'h0003, 32'd0, "errcnt_held_once");
    txn(16'h0007, 16'h0000, 32'd0, "illegal_cmd");
    check("fatal_after_illegal", 32'(fatal_err), 32'd0);
    txn(16'd2, 16'h0003, 32'd0, "errcnt_illegal");

    // Random register / RAM traffic
    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 0) begin
        lock = 4'($urandom);
        repeat (2) @(negedge clk);
      end
      ram_ena = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0:       a = 16'($urandom_range(0, 5));
        1, 2:    a = 16'h0100 + 16'($urandom_range(0, 15));
        3:       a = 16'h01FF;
        4:       a = 16'($urandom_range(16'h0200, 16'hFFFF));
        default: a = 16'($urandom_range(6, 16'h00FF));
      endcase
      d = $urandom;
      if (a == 16'h0001) d[0] = 1'b0;
      case ($urandom_range(0, 19))
        0:                 c = 16'd3;
        1:                 c = 16'($urandom_range(4, 16'hFFFF));
        2, 3, 4, 5, 6, 7, 8: c = 16'd1;
        default:           c = 16'd2;
      endcase
      txn(c, a, d, "rand");
      if (i % 25 == 24) txn(16'd2, 16'h0003, 32'd0, "rand_errcnt");
    end
    ram_ena = 1'b1;

    // Init completes via init_done
    txn(16'd1, 16'h0001, 32'd1, "wr_ctrl_start");
    check("init_start_on", 32'(init_start), 32'd1);
    txn(16'd1, 16'h0001, 32'd1, "wr_ctrl_busy");
    repeat (33) @(negedge clk);
    init_done = 1'b1;
    m_done    = 1'b1;
    for (int k = 0; k < 4 && init_start; k++) @(negedge clk);
    check("init_done_ack", 32'(init_start), 32'd0);
    m_busy = 1'b0;
    txn(16'd2, 16'h0002, 32'd0, "status_done");
    txn(16'd2, 16'h0003, 32'd0, "errcnt_busy_write");

    // Init times out
    init_done = 1'b0;
    m_done    = 1'b0;
    repeat (3) @(negedge clk);
    txn(16'd1, 16'h0001, 32'd1, "wr_ctrl_start2");
    repeat (95) @(negedge clk);
    check("pre_timeout_fatal", 32'(fatal_err), 32'd0);
    check("pre_timeout_start", 32'(init_start), 32'd1);
    repeat (3) @(negedge clk);
    check("timeout_fatal", 32'(fatal_err), 32'd1);
    check("timeout_start", 32'(init_start), 32'd0);
    m_busy    = 1'b0;
    m_timeout = 1'b1;
    txn(16'd2, 16'h0002, 32'd0, "status_timeout");
    txn(16'd1, 16'h0001, 32'd1, "wr_ctrl_fault");
    txn(16'd2, 16'h0003, 32'd0, "errcnt_fault");
    txn(16'd3, 16'h0000, 32'd0, "clr_err");
    check("clr_fatal", 32'(fatal_err), 32'd0);
    txn(16'd2, 16'h0003, 32'd0, "errcnt_cleared");
    txn(16'd2, 16'h0002, 32'd0, "status_cleared");

    // Freeze mid-init with a WRITE pending
    txn(16'd1, 16'h0000, 32'h5555_AAAA, "wr_scratch2");
    txn(16'd1, 16'h0001, 32'd1, "wr_ctrl_start3");
    repeat (10) @(negedge clk);
    freeze = 1'b1;
    cmd = 16'd1; addr = 16'h0000; din = 32'hDEAD_BEEF;
    repeat (49) @(negedge clk);
    check("freeze_start_hold", 32'(init_start), 32'd1);
    cmd = 16'd0;
    @(negedge clk);
    freeze = 1'b0;
    repeat (84) @(negedge clk);
    check("freeze_no_early_timeout", 32'(fatal_err), 32'd0);
    repeat (4) @(negedge clk);
    check("freeze_late_timeout", 32'(fatal_err), 32'd1);
    m_busy    = 1'b0;
    m_timeout = 1'b1;
    txn(16'd2, 16'h0000, 32'd0, "scratch_after_freeze");

    // Reset in the middle of a READ
    @(negedge clk);
    cmd = 16'd2; addr = 16'h0004;
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    check("arst_dout", dout, 32'd0);
    check("arst_fatal", 32'(fatal_err), 32'd0);
    check("arst_init_start", 32'(init_start), 32'd0);
    cmd  = 16'd0;
    arst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    txn(16'd2, 16'h0000, 32'd0, "post_rst_scratch");
    txn(16'd2, 16'h0003, 32'd0, "post_rst_errcnt");
    txn(16'd1, 16'h0001, 32'd1, "post_rst_ctrl");
    check("post_rst_init_start", 32'(init_start), 32'd1);
    txn(16'd2, 16'h0003, 32'd0, "post_rst_errcnt2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
